// File: rtl/dbg_loader_pkg.sv
// rtl/dbg_loader_pkg.sv - frame byte constants and FSM state encoding for dbg_loader
// S_CSUM exists only when DBG_LOADER_CHECKSUM_EN is defined.
package dbg_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;
   localparam logic [7:0] CMD_HALT  = 8'h03;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_CNT,
      S_DATA,
      S_WAIT_WR,
      S_RESP
`ifdef DBG_LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

endpackage

// File: rtl/dbg_loader_wr.sv
// rtl/dbg_loader_wr.sv - debug memory write pulse generator, holds one word write for WR_CYCLES cycles
// Address/data registers clear on the last cycle so the port reads 0 outside write windows.
module dbg_loader_wr
   import dbg_loader_pkg::*;
#(
   parameter int WR_CYCLES = 4
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        i_start,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_data,
   output logic        o_mem_op,
   output logic [3:0]  o_wren,
   output logic [31:0] o_adr,
   output logic [31:0] o_do,
   output logic        o_busy,
   output logic        o_last
);

   localparam int CW = $clog2(WR_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic [31:0]   r_adr;
   logic [31:0]   r_do;
   logic          w_busy;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_cnt <= '0;
         r_adr <= '0;
         r_do  <= '0;
      end else if (i_start) begin
         r_cnt <= CW'(WR_CYCLES);
         r_adr <= i_adr;
         r_do  <= i_data;
      end else if (w_busy) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            r_adr <= '0;
            r_do  <= '0;
         end
      end
   end

   assign w_busy   = (r_cnt != '0);
   assign o_busy   = w_busy;
   assign o_last   = (r_cnt == CW'(1));
   assign o_mem_op = w_busy;
   assign o_wren   = {4{w_busy}};
   assign o_adr    = r_adr;
   assign o_do     = r_do;

endmodule

// File: rtl/dbg_loader.sv
// rtl/dbg_loader.sv - UART-framed debug loader: writes program memory and controls CPU reset
// Optional trailing XOR checksum byte per frame enabled by DBG_LOADER_CHECKSUM_EN.
module dbg_loader
   import dbg_loader_pkg::*;
#(
   parameter int WR_CYCLES = 4,
   parameter int TIMEOUT   = 100000
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        cpu_n_reset,
   output logic        dbg_mem_op,
   output logic [3:0]  dbg_wren,
   output logic [31:0] dbg_adr,
   output logic [31:0] dbg_do
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        r_state;
   logic [31:0]   r_adr;
   logic [31:0]   r_word;
   logic [1:0]    r_idx;
   logic [8:0]    r_cnt;
   logic [TW-1:0] r_tmo;
   logic          r_nak;
   logic          r_tx_valid;
   logic [7:0]    r_tx_data;
   logic          r_cpu_n_reset;
`ifdef DBG_LOADER_CHECKSUM_EN
   logic [7:0]    r_csum;
   logic [7:0]    r_cmd;
`endif

   logic [31:0]   w_word;
   logic          w_start;
   logic          w_busy;
   logic          w_last;
   logic          w_tmo;

   assign w_word  = {rx_data, r_word[31:8]};
   assign w_start = rx_valid && (r_state == S_DATA) && (r_idx == 2'd3) && !w_busy;
   assign w_tmo   = !rx_valid && (r_state != S_IDLE) && (r_state != S_RESP)
                    && (r_tmo == TW'(TIMEOUT - 1));

   dbg_loader_wr #(.WR_CYCLES(WR_CYCLES)) u_wr (
      .clk      (clk),
      .n_reset  (n_reset),
      .i_start  (w_start),
      .i_adr    (r_adr),
      .i_data   (w_word),
      .o_mem_op (dbg_mem_op),
      .o_wren   (dbg_wren),
      .o_adr    (dbg_adr),
      .o_do     (dbg_do),
      .o_busy   (w_busy),
      .o_last   (w_last)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state       <= S_IDLE;
         r_adr         <= '0;
         r_word        <= '0;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_tmo         <= '0;
         r_nak         <= 1'b0;
         r_tx_valid    <= 1'b0;
         r_tx_data     <= '0;
         r_cpu_n_reset <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
         r_csum        <= '0;
         r_cmd         <= '0;
`endif
      end else begin
         if (rx_valid || r_state == S_IDLE || r_state == S_RESP)
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + TW'(1);
`ifdef DBG_LOADER_CHECKSUM_EN
         if (r_state == S_IDLE)
            r_csum <= '0;
         else if (rx_valid && (r_state == S_CMD || r_state == S_ADDR
                               || r_state == S_CNT || r_state == S_DATA))
            r_csum <= r_csum ^ rx_data;
`endif
         if (w_tmo) begin
            r_state    <= S_RESP;
            r_tx_valid <= 1'b1;
            r_tx_data  <= NAK_BYTE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_nak <= 1'b0;
                  if (rx_valid && rx_data == SYNC_BYTE)
                     r_state <= S_CMD;
               end
               S_CMD: if (rx_valid) begin
                  r_idx <= '0;
`ifdef DBG_LOADER_CHECKSUM_EN
                  r_cmd <= rx_data;
`endif
                  case (rx_data)
                     CMD_WRITE: begin
                        r_cpu_n_reset <= 1'b0;
                        r_state       <= S_ADDR;
                     end
                     CMD_RUN, CMD_HALT: begin
`ifdef DBG_LOADER_CHECKSUM_EN
                        r_state       <= S_CSUM;
`else
                        r_cpu_n_reset <= (rx_data == CMD_RUN);
                        r_state       <= S_RESP;
                        r_tx_valid    <= 1'b1;
                        r_tx_data     <= ACK_BYTE;
`endif
                     end
                     default: begin
                        r_state    <= S_RESP;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= NAK_BYTE;
                     end
                  endcase
               end
               S_ADDR: if (rx_valid) begin
                  r_adr <= {rx_data, r_adr[31:8]};
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3)
                     r_state <= S_CNT;
               end
               S_CNT: if (rx_valid) begin
                  // A count byte of zero encodes 256 words.
                  r_cnt   <= {rx_data == 8'h00, rx_data};
                  r_state <= S_DATA;
               end
               S_DATA: if (rx_valid) begin
                  r_word <= w_word;
                  r_idx  <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     if (w_busy) begin
                        r_nak   <= 1'b1;
                        r_state <= S_WAIT_WR;
                     end else begin
                        r_adr <= r_adr + 32'd4;
                        r_cnt <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1)
`ifdef DBG_LOADER_CHECKSUM_EN
                           r_state <= S_CSUM;
`else
                           r_state <= S_WAIT_WR;
`endif
                     end
                  end
               end
`ifdef DBG_LOADER_CHECKSUM_EN
               S_CSUM: if (rx_valid) begin
                  if (r_cmd == CMD_WRITE) begin
                     r_nak   <= (rx_data != r_csum);
                     r_state <= S_WAIT_WR;
                  end else begin
                     if (rx_data == r_csum)
                        r_cpu_n_reset <= (r_cmd == CMD_RUN);
                     r_state    <= S_RESP;
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= (rx_data == r_csum) ? ACK_BYTE : NAK_BYTE;
                  end
               end
`endif
               S_WAIT_WR: if (!w_busy || w_last) begin
                  r_state    <= S_RESP;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= r_nak ? NAK_BYTE : ACK_BYTE;
               end
               S_RESP: if (tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_tx_data;
   assign cpu_n_reset = r_cpu_n_reset;

endmodule

// File: tb/tb_dbg_loader.sv
// tb/tb_dbg_loader.sv - self-checking bench for dbg_loader, frame table plus hand-written corner sequences
// Checksum vectors and byte appending activate when DBG_LOADER_CHECKSUM_EN is defined.
module tb_dbg_loader;

`ifdef DBG_LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif
   localparam int WRC = 4;
   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cpu_n_reset;
   logic        dbg_mem_op;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr;
   logic [31:0] dbg_do;

   always #5 clk = ~clk;

   dbg_loader #(.WR_CYCLES(WRC), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .cpu_n_reset (cpu_n_reset),
      .dbg_mem_op  (dbg_mem_op),
      .dbg_wren    (dbg_wren),
      .dbg_adr     (dbg_adr),
      .dbg_do      (dbg_do)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      string        name;
      logic [127:0] fr;
      int           n;
      bit           cs;
      logic [7:0]   resp;
      logic         cpu;
      int           nwr;
      logic [31:0]  adr0, do0, adrl, dol;
   } vec_t;
   vec_t vecs[$];

   // Write-window monitor: records each dbg_mem_op pulse and flags port misbehaviour.
   logic [31:0] wr_adr_q[$], wr_do_q[$];
   int          wr_len_q[$];
   int          mon_err = 0;
   bit          in_wr = 0;
   int          cur_len;
   logic [31:0] cur_adr, cur_do;

   always @(negedge clk) begin
      if (dbg_mem_op) begin
         if (!in_wr) begin
            in_wr = 1; cur_len = 1; cur_adr = dbg_adr; cur_do = dbg_do;
         end else begin
            cur_len++;
            if (dbg_adr !== cur_adr || dbg_do !== cur_do) mon_err++;
         end
         if (dbg_wren !== 4'hF) mon_err++;
      end else begin
         if (in_wr) begin
            wr_adr_q.push_back(cur_adr); wr_do_q.push_back(cur_do); wr_len_q.push_back(cur_len);
            in_wr = 0;
         end
         if (dbg_wren !== 4'h0 || dbg_adr !== 32'h0 || dbg_do !== 32'h0) mon_err++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      wr_adr_q.delete(); wr_do_q.delete(); wr_len_q.delete(); mon_err = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'h00;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [127:0] fr, input int n, input bit cs);
      logic [7:0] b, x;
      x = 8'h00;
      for (int j = 0; j < n; j++) begin
         b = fr[8*(n-1-j) +: 8];
         if (j > 0) x ^= b;
         send_byte(b, WRC + 1);
      end
      if (cs && CSUM_ON) send_byte(x, WRC + 1);
   endtask

   task automatic get_resp(input string nm, input logic [7:0] exp);
      int k;
      k = 0;
      while (!tx_valid && k < 300) begin @(negedge clk); k++; end
      check({nm, "_valid"}, tx_valid, 1);
      if (tx_valid) begin
         check({nm, "_resp"}, tx_data, exp);
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
         check({nm, "_accept"}, tx_valid, 0);
      end
   endtask

   task automatic add(input string nm, input logic [127:0] fr, input int n, input bit cs,
                      input logic [7:0] resp, input logic cpu, input int nwr,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] al, input logic [31:0] dl);
      vec_t v;
      v.name = nm; v.fr = fr; v.n = n; v.cs = cs; v.resp = resp; v.cpu = cpu; v.nwr = nwr;
      v.adr0 = a0; v.do0 = d0; v.adrl = al; v.dol = dl;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] mo, txv;
      bit seen;
      n_reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

      add("wr1",    128'hA5_01_00_00_02_00_01_6F_00_00_00, 11, 1, 8'h06, 1'b0, 1,
          32'h20000, 32'h6F, 32'h20000, 32'h6F);
      add("wr2",    128'hA5_01_04_00_02_00_02_01_00_00_00_02_00_00_00, 15, 1, 8'h06, 1'b0, 2,
          32'h20004, 32'h1, 32'h20008, 32'h2);
      add("run",    128'hA5_02, 2, 1, 8'h06, 1'b1, 0, 0, 0, 0, 0);
      add("halt",   128'hA5_03, 2, 1, 8'h06, 1'b0, 0, 0, 0, 0, 0);
      add("run2",   128'hA5_02, 2, 1, 8'h06, 1'b1, 0, 0, 0, 0, 0);
      add("wrap",   128'hA5_01_FC_FF_FF_FF_02_EF_BE_AD_DE_78_56_34_12, 15, 1, 8'h06, 1'b0, 2,
          32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0, 32'h1234_5678);
      add("unk",    128'hA5_07, 2, 0, 8'h15, 1'b0, 0, 0, 0, 0, 0);
`ifdef DBG_LOADER_CHECKSUM_EN
      add("cs_bad_run", 128'hA5_02_00, 3, 0, 8'h15, 1'b0, 0, 0, 0, 0, 0);
      add("cs_ok_run",  128'hA5_02_02, 3, 0, 8'h06, 1'b1, 0, 0, 0, 0, 0);
      add("cs_bad_wr",  128'hA5_01_00_00_02_00_01_6F_00_00_00_00, 12, 0, 8'h15, 1'b0, 1,
          32'h20000, 32'h6F, 32'h20000, 32'h6F);
`endif

      repeat (3) @(negedge clk);
      check("rst_ctl", {cpu_n_reset, dbg_mem_op, dbg_wren, tx_valid, tx_data}, 0);
      check("rst_adr", dbg_adr, 0);
      check("rst_do", dbg_do, 0);
      n_reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         clear_mon();
         send_frame(vecs[i].fr, vecs[i].n, vecs[i].cs);
         get_resp(vecs[i].name, vecs[i].resp);
         check({vecs[i].name, "_cpu"}, cpu_n_reset, vecs[i].cpu);
         check({vecs[i].name, "_nwr"}, wr_adr_q.size(), vecs[i].nwr);
         if (vecs[i].nwr > 0 && wr_adr_q.size() == vecs[i].nwr) begin
            check({vecs[i].name, "_adr0"}, wr_adr_q[0], vecs[i].adr0);
            check({vecs[i].name, "_do0"}, wr_do_q[0], vecs[i].do0);
            check({vecs[i].name, "_adrl"}, wr_adr_q[vecs[i].nwr-1], vecs[i].adrl);
            check({vecs[i].name, "_dol"}, wr_do_q[vecs[i].nwr-1], vecs[i].dol);
            foreach (wr_len_q[j]) check({vecs[i].name, "_len"}, wr_len_q[j], WRC);
         end
         check({vecs[i].name, "_mon"}, mon_err, 0);
      end

      // WRITE while running drops cpu_n_reset the cycle after the CMD byte.
      send_frame(128'hA5_02, 2, 1);
      get_resp("pre_run", 8'h06);
      check("pre_run_cpu", cpu_n_reset, 1);
      clear_mon();
      send_byte(8'hA5, WRC + 1);
      rx_data = 8'h01; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("cpu_after_cmd", cpu_n_reset, 0);
      repeat (WRC + 1) @(negedge clk);
      send_frame(128'h00_00_05_00_01_AA_BB_CC_DD, 9, 0);
      if (CSUM_ON) send_byte(8'h05, WRC + 1);
      get_resp("run_wr", 8'h06);
      check("run_wr_cpu", cpu_n_reset, 0);
      check("run_wr_nwr", wr_adr_q.size(), 1);
      if (wr_adr_q.size() == 1) begin
         check("run_wr_adr", wr_adr_q[0], 32'h50000);
         check("run_wr_do", wr_do_q[0], 32'hDDCC_BBAA);
      end

      // Garbage in IDLE produces nothing.
      send_byte(8'h00, WRC + 1);
      send_byte(8'hFF, WRC + 1);
      seen = 0;
      repeat (20) begin seen |= tx_valid; @(negedge clk); end
      check("garbage_quiet", seen, 0);
      send_frame(128'hA5_03, 2, 1);
      get_resp("after_garbage", 8'h06);

      // Write window timing relative to the last data byte.
      clear_mon();
      send_frame(128'hA5_01_00_00_03_00_01_01_02_03, 10, 0);
      rx_data = 8'h04; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      mo = '0; txv = '0;
      for (int k = 0; k < 6; k++) begin
         mo = {mo[4:0], dbg_mem_op}; txv = {txv[4:0], tx_valid};
         @(negedge clk);
      end
      check("win_mem_op", mo, 6'b111100);
`ifndef DBG_LOADER_CHECKSUM_EN
      check("win_tx_valid", txv, 6'b000011);
`endif
      if (CSUM_ON) send_byte(8'h07, WRC + 1);
      get_resp("win", 8'h06);
      check("win_nwr", wr_adr_q.size(), 1);
      if (wr_adr_q.size() == 1) begin
         check("win_adr", wr_adr_q[0], 32'h30000);
         check("win_do", wr_do_q[0], 32'h0403_0201);
      end

      // Timeout after two address bytes.
      clear_mon();
      send_frame(128'hA5_01_00_00, 4, 0);
      repeat (150) @(negedge clk);
      check("tmo_early", tx_valid, 0);
      get_resp("tmo", 8'h15);
      check("tmo_nwr", wr_adr_q.size(), 0);

      // Overrun: second word completes inside the first write window.
      clear_mon();
      send_frame(128'hA5_01_00_01_00_00_02, 7, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
      get_resp("ovr", 8'h15);
      check("ovr_nwr", wr_adr_q.size(), 1);
      if (wr_adr_q.size() == 1) begin
         check("ovr_adr", wr_adr_q[0], 32'h100);
         check("ovr_do", wr_do_q[0], 32'h4433_2211);
         check("ovr_len", wr_len_q[0], WRC);
      end
      check("ovr_mon", mon_err, 0);

      // Asynchronous reset in the middle of a write window.
      clear_mon();
      send_frame(128'hA5_01_00_00_04_00_01_01_02_03, 10, 0);
      rx_data = 8'h04; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("rst_mid_pre", dbg_mem_op, 1);
      #2 n_reset = 1'b0;
      #1;
      check("rst_mid_ctl", {cpu_n_reset, dbg_mem_op, dbg_wren, tx_valid, tx_data}, 0);
      check("rst_mid_adr", dbg_adr, 0);
      check("rst_mid_do", dbg_do, 0);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      clear_mon();
      send_frame(128'hA5_02, 2, 1);
      get_resp("post_rst", 8'h06);
      check("post_rst_cpu", cpu_n_reset, 1);
      check("post_rst_mon", mon_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
